fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath's decode/register-file input. It owns the fetch PC, drives the combinational instruction memory, and buffers fetched {pc, instr} pairs in a small FIFO. The pairs are handed downstream over a valid/ready handshake. A redirect port lets the branch path (`pc_src`/`pc_branch`) flush the queue and restart fetch at a new address.

---
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-stage bus bundle (imem port, instruction stream, redirect).
// Modports: master = fetch stage side, slave = environment/consumer side.
interface fetch_queue_if #(
    parameter int n = 32
);
    logic         fetch_en;
    logic [n-1:0] imem_addr;
    logic [n-1:0] imem_rdata;
    logic         instr_valid;
    logic [n-1:0] instr;
    logic [n-1:0] instr_pc;
    logic         instr_ready;
    logic         redirect;
    logic [n-1:0] redirect_pc;

    modport master (
        input  fetch_en,
        input  imem_rdata,
        input  instr_ready,
        input  redirect,
        input  redirect_pc,
        output imem_addr,
        output instr_valid,
        output instr,
        output instr_pc
    );

    modport slave (
        output fetch_en,
        output imem_rdata,
        output instr_ready,
        output redirect,
        output redirect_pc,
        input  imem_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, reads imem, buffers {pc, instr} in a FIFO.
// Ports: CLK, rst (async active-high), bus (fetch_queue_if.master).
// Optional FETCH_QUEUE_PERF_EN adds fetch_cnt / flush_cnt outputs.
module fetch_queue #(
    parameter int             n        = 32,
    parameter int             DEPTH    = 4,
    parameter logic [n-1:0]   RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          rst,
    fetch_queue_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [n-1:0]  fpc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [n-1:0]  mem_pc    [DEPTH];
    logic [n-1:0]  mem_instr [DEPTH];

    logic run;
    logic pop;
    logic push;

    assign run  = (state == RUN);
    assign pop  = bus.instr_valid & bus.instr_ready & ~bus.redirect;
    // A pop frees the head slot this edge, so a full queue can still push.
    assign push = run & bus.fetch_en & ~bus.redirect &
                  ((count < CW'(DEPTH)) | pop);

    assign bus.imem_addr   = fpc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = mem_instr[head];
    assign bus.instr_pc    = mem_pc[head];

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            fpc   <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= RUN;
            if (bus.redirect) begin
                fpc   <= bus.redirect_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    fpc  <= fpc + n'(4);
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (push) begin
            mem_pc[tail]    <= fpc;
            mem_instr[tail] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (run && bus.redirect) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a queue-based model.
// Stimulus updates the model after each edge; a negedge monitor checks pops.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XORK     = 32'hA5A5_0000;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    fetch_queue_if #(.n(32)) bus ();
    assign bus.imem_rdata = bus.imem_addr ^ XORK;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    fetch_queue #(
        .n(32),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .fetch_cnt(fetch_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        sb[$];
    int          exp_count = 0;
    logic [31:0] exp_fpc   = RESET_PC;
    bit          exp_run   = 1'b0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_flush = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: a list of fetched entries, a PC and an occupancy counter.
    task automatic model_edge();
        bit p;
        bit q;
        if (rst) return;
        if (!exp_run) begin
            if (bus.redirect) exp_fpc = bus.redirect_pc;
            exp_run = 1'b1;
        end else if (bus.redirect) begin
            sb.delete();
            exp_count = 0;
            exp_fpc   = bus.redirect_pc;
            exp_flush = exp_flush + 1;
        end else begin
            p = (exp_count > 0) && bus.instr_ready;
            q = bus.fetch_en && ((exp_count < DEPTH) || p);
            if (p) exp_count--;
            if (q) begin
                sb.push_back('{exp_fpc, exp_fpc ^ XORK});
                exp_count++;
                exp_fpc   = exp_fpc + 32'd4;
                exp_fetch = exp_fetch + 1;
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_count = 0;
        exp_fpc   = RESET_PC;
        exp_run   = 1'b0;
        exp_fetch = '0;
        exp_flush = '0;
    endtask

    task automatic step(input bit fe, input bit rdy, input bit rd,
                        input logic [31:0] rpc);
        bus.fetch_en    = fe;
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge CLK);
        #1;
        model_edge();
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_addr", bus.imem_addr, RESET_PC);
        model_reset();
        @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge CLK) begin : monitor
        ent_t e;
        chk("imem_addr", bus.imem_addr, exp_fpc);
        chk("instr_valid", 32'(bus.instr_valid), 32'(exp_count != 0));
        if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty actual pc %h required no entry",
                         bus.instr_pc);
            end else begin
                e = sb.pop_front();
                chk("instr_pc", bus.instr_pc, e.pc);
                chk("instr", bus.instr, e.ins);
            end
        end
`ifdef FETCH_QUEUE_PERF_EN
        chk("fetch_cnt", fetch_cnt, exp_fetch);
        chk("flush_cnt", flush_cnt, exp_flush);
`endif
    end

    initial begin
        bus.fetch_en    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        rst = 1'b0;

        // Boot then stall: queue fills with 0,4,8,12 and fetch holds at 16.
        step(1, 0, 0, '0);
        chk("boot_valid", 32'(bus.instr_valid), 32'd0);
        step(1, 0, 0, '0);
        chk("first_pc", bus.instr_pc, 32'd0);
        repeat (9) step(1, 0, 0, '0);
        chk("sat_addr", bus.imem_addr, 32'h10);
        chk("sat_valid", 32'(bus.instr_valid), 32'd1);

        // Full with ready high: one push and one pop per edge.
        repeat (5) step(1, 1, 0, '0);
        chk("thru_addr", bus.imem_addr, 32'h24);

        // Drop to 3 entries, then redirect with ready high.
        step(0, 1, 0, '0);
        step(1, 1, 1, 32'h0000_0100);
        chk("redir_valid", 32'(bus.instr_valid), 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        step(1, 1, 0, '0);
        chk("redir_pc", bus.instr_pc, 32'h100);
        repeat (4) step(1, 1, 0, '0);

        // Address wrap.
        step(1, 1, 1, 32'hFFFF_FFF8);
        repeat (4) step(1, 1, 0, '0);

        // Async reset with two entries queued.
        step(1, 0, 1, 32'h40);
        repeat (2) step(1, 0, 0, '0);
        chk("two_valid", 32'(bus.instr_valid), 32'd1);
        async_reset();
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        chk("reboot_pc", bus.instr_pc, RESET_PC);
        repeat (6) step(1, 1, 0, '0);

        // Redirect taken while still in BOOT.
        async_reset();
        step(1, 1, 1, 32'h0000_0300);
        step(1, 1, 0, '0);
        chk("boot_redir_pc", bus.instr_pc, 32'h300);
        repeat (4) step(1, 1, 0, '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 8) != 0, ($urandom % 3) != 0,
                 ($urandom % 25) == 0,
                 (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        end
        repeat (8) step(0, 1, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
